// File: rtl/reg4_pkg.sv
// Shared types and constants for the 4-bit universal register sequencer.
//   state_e      : controller FSM states
//   MODO_CARGA   : register mode for parallel load
//   MODO_REPOSO  : register mode driven while idle
//   CNT_W_DEF    : default width of run-length / RCO-count fields
package reg4_pkg;
  localparam int          CNT_W_DEF   = 8;
  localparam logic [1:0]  MODO_CARGA  = 2'b11;
  localparam logic [1:0]  MODO_REPOSO = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/reg4_contador_sat.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear to zero (wins over inc)
//   inc      : increment by one, sticking at all-ones
//   cnt      : current count
module reg4_contador_sat #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/reg4_secuenciador.sv
// Command-driven sequencer for a 4-bit universal register: parallel load of
// CMD_D, then up to CMD_N run cycles in CMD_MODO, then a one-cycle DONE.
//   CMD_*            : command fields, valid/ready handshake (accepted in IDLE)
//   ABORT            : end the current LOAD/RUN early (reported via ABORTADO)
//   ENB/MODO/D       : drive to the register; Q/RCO monitored back
//   DONE/ABORTADO    : completion pulse and abort flag
//   Q_FINAL/RCO_CNT  : results of the last command, updated as DONE ends
//   BUSY             : high while a command is in LOAD/RUN/DONE
module reg4_secuenciador #(
  parameter int         CNT_W      = reg4_pkg::CNT_W_DEF,
  parameter logic [1:0] MODO_CARGA = reg4_pkg::MODO_CARGA
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_MODO,
  input  logic [3:0]       CMD_D,
  input  logic [CNT_W-1:0] CMD_N,
  input  logic             CMD_STOP_RCO,
  input  logic             ABORT,
  output logic             ENB,
  output logic [1:0]       MODO,
  output logic [3:0]       D,
  input  logic [3:0]       Q,
  input  logic             RCO,
  output logic             DONE,
  output logic             ABORTADO,
  output logic [3:0]       Q_FINAL,
  output logic [CNT_W-1:0] RCO_CNT,
  output logic             BUSY
);
  import reg4_pkg::*;

  state_e           state_q, state_d;
  logic [1:0]       modo_q, modo_d;
  logic [3:0]       d_q, d_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             abort_q, abort_d;
  logic [3:0]       q_final_q, q_final_d;
  logic [CNT_W-1:0] rco_cnt_q, rco_cnt_d;
  logic             cnt_clr, cnt_inc;
  logic [CNT_W-1:0] rco_cnt_live;

  reg4_contador_sat #(.CNT_W(CNT_W)) u_cnt_rco (
    .clk (CLK),
    .rst (RESET),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (rco_cnt_live)
  );

  always_comb begin
    state_d   = state_q;
    modo_d    = modo_q;
    d_d       = d_q;
    n_d       = n_q;
    stop_d    = stop_q;
    rem_d     = rem_q;
    abort_d   = abort_q;
    q_final_d = q_final_q;
    rco_cnt_d = rco_cnt_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          modo_d  = CMD_MODO;
          d_d     = CMD_D;
          n_d     = CMD_N;
          stop_d  = CMD_STOP_RCO;
          abort_d = 1'b0;
          cnt_clr = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rem_d = n_q;
        if (ABORT) begin
          abort_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = (n_q != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        rem_d   = rem_q - CNT_W'(1);
        cnt_inc = RCO;
        if (ABORT) abort_d = 1'b1;
        // Natural end, early RCO stop and abort all converge on DONE.
        if (rem_q == CNT_W'(1) || (stop_q && RCO) || ABORT)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        // Q here already reflects the edge that closed the last active cycle.
        q_final_d = Q;
        rco_cnt_d = rco_cnt_live;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      modo_q    <= MODO_REPOSO;
      d_q       <= 4'h0;
      n_q       <= '0;
      stop_q    <= 1'b0;
      rem_q     <= '0;
      abort_q   <= 1'b0;
      q_final_q <= 4'h0;
      rco_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      modo_q    <= modo_d;
      d_q       <= d_d;
      n_q       <= n_d;
      stop_q    <= stop_d;
      rem_q     <= rem_d;
      abort_q   <= abort_d;
      q_final_q <= q_final_d;
      rco_cnt_q <= rco_cnt_d;
    end
  end

  // Outputs are quiet during the reset cycle regardless of the current state.
  always_comb begin
    CMD_READY = 1'b0;
    ENB       = 1'b0;
    MODO      = MODO_REPOSO;
    D         = 4'h0;
    DONE      = 1'b0;
    ABORTADO  = 1'b0;
    BUSY      = 1'b0;
    if (!RESET) begin
      D    = d_q;
      BUSY = (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: CMD_READY = 1'b1;
        ST_LOAD: begin
          ENB  = 1'b1;
          MODO = MODO_CARGA;
        end
        ST_RUN: begin
          ENB  = 1'b1;
          MODO = modo_q;
        end
        ST_DONE: begin
          DONE     = 1'b1;
          ABORTADO = abort_q;
        end
        default: ;
      endcase
    end
  end

  assign Q_FINAL = q_final_q;
  assign RCO_CNT = rco_cnt_q;
endmodule
